reg_file_write_port: RTL and testbench
======================================

REG_FILE_WRITE_PORT -- requirements
Module: reg_file_write_port

Interface
REQ-001 Parameter DATA_W, 16, register width in bits.
REQ-002 Parameter NUM_REGS, 16, register count; fixed at 16 because the write id is 4 bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 wr_en  input  1  write request, sampled on rising clk.
REQ-006 wr_id  input  4  destination register id.
REQ-007 wr_data  input  DATA_W  write data.
REQ-008 rd_id_a  input  4  read port A register id.
REQ-009 rd_id_b  input  4  read port B register id.
REQ-010 rd_data_a  output  DATA_W  read port A data, combinational.
REQ-011 rd_data_b  output  DATA_W  read port B data, combinational.
REQ-012 wr_wordline  output  16  registered one-hot copy of the last accepted write's wordline; debug and scoreboard use.
REQ-013 wr_count  output  8  count of accepted writes; wraps.

Function
REQ-014 Write decode: wr_id selects exactly one wordline bit (bit n for id n); id 0 selects no wordline.
REQ-015 Accepted write: wr_en=1 and wr_id!=0; on that clk edge reg[wr_id] <= wr_data.
REQ-016 Write to id 0 is discarded: no register changes, wr_count unchanged, wr_wordline <= 16'h0000.
REQ-017 wr_en=0: no register changes, wr_wordline <= 16'h0000, wr_count holds.
REQ-018 Accepted write: wr_wordline <= one-hot(wr_id) one cycle later; wr_count <= wr_count+1 (modulo 256; 255 wraps to 0).
REQ-019 Read: rd_data_x = reg[rd_id_x]; rd_id_x=0 always returns 0.
REQ-020 Write-through bypass: if wr_en=1, wr_id!=0 and rd_id_x==wr_id in the same cycle, rd_data_x = wr_data combinationally.
REQ-021 Both read ports may address the same register, or the write target, at the same time; each port applies REQ-019/020 independently.
REQ-022 Write latency: new value is visible via the bypass in the write cycle and from storage in all later cycles.
REQ-023 No X on outputs after reset regardless of input activity.

Reset
REQ-024 rst_n low asynchronously clears all registers to 0, wr_wordline to 16'h0000 and wr_count to 0.
REQ-025 A write coincident with rst_n low is dropped; the bypass still forwards wr_data combinationally while reset is asserted.
REQ-026 Release of rst_n mid-stream: the first rising edge with rst_n high performs normal writes.

Structure
REQ-027 Shared package holds DATA_W, NUM_REGS, REG_ID_W=4 and the ZERO_REG=0 constant.
REQ-028 One sub-module: write_decoder_4_16 (4-bit id plus enable in, 16-bit one-hot wordline out, all-zero for id 0 or enable low); the register array, bypass and counters live in the top module.

Verification
REQ-029 Reset, then read all 16 ids on both ports -> all 0; wr_wordline=0; wr_count=0.
REQ-030 Write id 5 = 16'hBEEF -> next cycle wr_wordline=16'h0020, wr_count=1, rd_id_a=5 returns 16'hBEEF.
REQ-031 Write id 0 = 16'hFFFF -> rd id 0 = 0, wr_wordline=0, wr_count unchanged.
REQ-032 In one cycle: write id 9 = 16'h1234 with rd_id_a=9, rd_id_b=9 -> both return 16'h1234 in that cycle; the old value is not returned.
REQ-033 256 accepted writes -> wr_count wraps to 0; the last data written is readable.
REQ-034 Drop rst_n asynchronously between edges after writing id 15 = 16'hA5A5 -> rd id 15 = 0 immediately, with no clk edge required.

Source files
------------

// File: rtl/reg_file_write_port_pkg.sv
// Shared constants and helpers for the register-file write port.
package reg_file_write_port_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned REG_ID_W = 4;
  localparam int unsigned COUNT_W  = 8;

  // Register 0 is hard-wired: reads return zero and writes are discarded.
  localparam logic [REG_ID_W-1:0] ZERO_REG = '0;

  function automatic logic [NUM_REGS-1:0] id_to_onehot(logic [REG_ID_W-1:0] id);
    return NUM_REGS'(1) << id;
  endfunction

endpackage

// File: rtl/reg_file_write_port_decoder.sv
// 4-to-16 write wordline decoder; id 0 and a deasserted enable select nothing.
module write_decoder_4_16
  import reg_file_write_port_pkg::*;
(
  input  logic                en,
  input  logic [REG_ID_W-1:0] id,
  output logic [NUM_REGS-1:0] wordline
);

  always_comb begin
    wordline = '0;
    if (en && (id != ZERO_REG)) begin
      wordline = id_to_onehot(id);
    end
  end

endmodule

// File: rtl/reg_file_write_port.sv
// 16-entry register file with one write port, two combinational read ports
// and same-cycle write-through bypass.
module reg_file_write_port
  import reg_file_write_port_pkg::*;
#(
  parameter int unsigned DATA_W   = reg_file_write_port_pkg::DATA_W,
  parameter int unsigned NUM_REGS = reg_file_write_port_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [3:0]          wr_id,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [3:0]          rd_id_a,
  input  logic [3:0]          rd_id_b,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic [15:0]         wr_wordline,
  output logic [7:0]          wr_count
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [15:0]         wordline;
  logic [15:0]         wr_wordline_q;
  logic [COUNT_W-1:0]  wr_count_q;
  logic                wr_acc;

  write_decoder_4_16 u_decoder (
    .en       (wr_en),
    .id       (wr_id),
    .wordline (wordline)
  );

  assign wr_acc = |wordline;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wordline[i]) begin
          regs_q[i] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_wordline_q <= '0;
      wr_count_q    <= '0;
    end else begin
      wr_wordline_q <= wordline;
      if (wr_acc) begin
        wr_count_q <= wr_count_q + COUNT_W'(1);
      end
    end
  end

  // Bypass is independent of reset so in-flight data is forwarded even then.
  function automatic logic [DATA_W-1:0] read_port(logic [REG_ID_W-1:0] id);
    logic [DATA_W-1:0] data;
    data = '0;
    if (id != ZERO_REG) begin
      if (wr_acc && (id == wr_id)) begin
        data = wr_data;
      end else begin
        data = regs_q[id];
      end
    end
    return data;
  endfunction

  always_comb begin
    rd_data_a = read_port(rd_id_a);
    rd_data_b = read_port(rd_id_b);
  end

  assign wr_wordline = wr_wordline_q;
  assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_reg_file_write_port.sv
// Scoreboard bench for reg_file_write_port: directed and random traffic.
module tb_reg_file_write_port;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] wl;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_id;
  logic [15:0] wr_data;
  logic [3:0]  rd_id_a;
  logic [3:0]  rd_id_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic [15:0] wr_wordline;
  logic [7:0]  wr_count;

  exp_t        sb[$];
  int          tests;
  int          fails;

  // Reference model state: register contents as seen after the most recent edge.
  logic [15:0] mem [16];
  logic [15:0] wl_m;
  int          cnt_m;

  reg_file_write_port dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_id       (wr_id),
    .wr_data     (wr_data),
    .rd_id_a     (rd_id_a),
    .rd_id_b     (rd_id_b),
    .rd_data_a   (rd_data_a),
    .rd_data_b   (rd_data_b),
    .wr_wordline (wr_wordline),
    .wr_count    (wr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, after inputs have settled.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("rd_data_a", rd_data_a, e.a);
      check("rd_data_b", rd_data_b, e.b);
      check("wr_wordline", wr_wordline, e.wl);
      check("wr_count", {8'h00, wr_count}, {8'h00, e.cnt});
    end
  end

  function automatic logic [15:0] model_read(input logic [3:0] rd, input logic en,
                                             input logic [3:0] id, input logic [15:0] data);
    if (rd == 4'd0) return 16'h0000;
    if (en && id != 4'd0 && rd == id) return data;
    return mem[rd];
  endfunction

  task automatic drive(input logic rst, input logic en, input logic [3:0] id,
                       input logic [15:0] data, input logic [3:0] ra, input logic [3:0] rb);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n   = rst;
    wr_en   = en;
    wr_id   = id;
    wr_data = data;
    rd_id_a = ra;
    rd_id_b = rb;
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
      wl_m  = 16'h0000;
      cnt_m = 0;
    end
    e.a   = model_read(ra, en, id, data);
    e.b   = model_read(rb, en, id, data);
    e.wl  = wl_m;
    e.cnt = 8'(cnt_m);
    sb.push_back(e);
    // Advance model to the state after the coming edge.
    if (rst) begin
      if (en && id != 4'd0) begin
        mem[id] = data;
        wl_m    = 16'h0001 << id;
        cnt_m   = (cnt_m + 1) % 256;
      end else begin
        wl_m = 16'h0000;
      end
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_id   = 4'd0;
    wr_data = 16'h0000;
    rd_id_a = 4'd0;
    rd_id_b = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    wl_m  = 16'h0000;
    cnt_m = 0;

    drive(1'b0, 1'b1, 4'd3, 16'h1111, 4'd3, 4'd0);
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd0);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'(i), 4'(15 - i));

    drive(1'b1, 1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd0);
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd5);
    drive(1'b1, 1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd5);
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
    drive(1'b1, 1'b1, 4'd9, 16'h1234, 4'd9, 4'd9);
    drive(1'b1, 1'b1, 4'd9, 16'h5678, 4'd9, 4'd5);
    drive(1'b1, 1'b0, 4'd9, 16'hDEAD, 4'd9, 4'd9);

    for (int i = 0; i < 255; i++) begin
      drive(1'b1, 1'b1, 4'($urandom_range(15, 1)), 16'($urandom), 4'($urandom), 4'($urandom));
    end
    drive(1'b1, 1'b1, 4'd7, 16'hC0DE, 4'd7, 4'd0);
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd7, 4'd7);

    drive(1'b1, 1'b1, 4'd15, 16'hA5A5, 4'd15, 4'd0);
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 4'd15, 4'd15);
    drive(1'b0, 1'b1, 4'd6, 16'h7777, 4'd6, 4'd15);
    drive(1'b1, 1'b1, 4'd6, 16'h4242, 4'd6, 4'd15);
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd6, 4'd0);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(59, 0) != 0), 1'($urandom), 4'($urandom), 16'($urandom),
            4'($urandom), 4'($urandom));
    end
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
